// File: rtl/ad1_pkg.sv
// Shared types and constants for the PMOD AD1 serial receiver.
//   state_t    : receiver FSM states (IDLE, SHIFT, QUIET)
//   FRAME_BITS : sclk falls per conversion frame
//   DATA_BITS  : useful sample bits (LSBs of the frame)
//   LEAD_ZEROS : leading bits the ADC always sends as zero
//   TOGGLES    : sclk edges per frame (one fall + one rise per bit)
package ad1_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 12;
  localparam int LEAD_ZEROS = 4;
  localparam int TOGGLES    = 2 * FRAME_BITS;

endpackage

// File: rtl/ad1_sclk_gen.sv
// Serial clock generator for the AD1 receiver.
// Divides clk by 2*CLK_DIV while run is high; sclk idles high.
// Ports:
//   clk, reset_b : system clock, async active-low reset
//   clr          : hold divider/toggle count at zero and sclk high
//   run          : advance the divider (frame in progress)
//   sclk         : registered serial clock
//   fall_tick    : high on the clk edge that drives sclk high->low
//   rise_tick    : high on the clk edge that drives sclk low->high
//   done         : high on the edge producing the last (32nd) toggle
module ad1_sclk_gen
  import ad1_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clr,
  input  logic run,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick,
  output logic done
);

  logic [7:0] div_cnt;
  logic [5:0] tog_cnt;
  logic       term;

  assign term      = run && (div_cnt == 8'(CLK_DIV - 1));
  // Strobes are combinational so the consumer acts on the same edge
  // that moves sclk; sclk itself is the pre-edge level here.
  assign fall_tick = term && sclk;
  assign rise_tick = term && !sclk;
  assign done      = rise_tick && (tog_cnt == 6'(TOGGLES - 1));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      div_cnt <= '0;
      tog_cnt <= '0;
      sclk    <= 1'b1;
    end else if (clr) begin
      div_cnt <= '0;
      tog_cnt <= '0;
      sclk    <= 1'b1;
    end else if (run) begin
      if (term) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        tog_cnt <= tog_cnt + 6'd1;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pmod_ad1_rx.sv
// PMOD AD1 dual-channel 12-bit ADC receiver (SPI-style master).
// Each frame drops CS, clocks 16 sclk cycles, shifts both MISO lines in
// MSB first and presents the low 12 bits of each with a 1-clk valid.
// Channel 0 = setpoint, channel 1 = process value.
// Optional build macro AD1_LEAD_ZERO_CHECK_EN: flags frames whose four
// leading bits are not zero on frame_err; otherwise frame_err is 0.
// Ports:
//   clk, reset_b        : system clock, async active-low reset
//   conv_en             : level, frames run back-to-back while high
//   adc_miso0/1         : serial data from the ADC, channels 0/1
//   adc_cs_out          : chip select, active low
//   adc_sclk            : serial clock, idles high
//   sample0/sample1     : last completed samples, held between frames
//   sample_valid        : 1-clk pulse when samples update
//   busy                : high while CS is low
//   frame_err           : leading-zero violation of the last frame
module pmod_ad1_rx
  import ad1_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int QUIET_CLKS = 8
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 conv_en,
  input  logic                 adc_miso0,
  input  logic                 adc_miso1,
  output logic                 adc_cs_out,
  output logic                 adc_sclk,
  output logic [DATA_BITS-1:0] sample0,
  output logic [DATA_BITS-1:0] sample1,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int Q_W = (QUIET_CLKS > 1) ? $clog2(QUIET_CLKS) : 1;

  // Without the check the leading bits are never looked at, so the shift
  // registers only keep the last DATA_BITS bits of the frame.
`ifdef AD1_LEAD_ZERO_CHECK_EN
  localparam int SREG_W = FRAME_BITS;
`else
  localparam int SREG_W = DATA_BITS;
`endif

  state_t            state;
  logic [4:0]        bit_cnt;
  logic [SREG_W-1:0] sreg0, sreg1;
  logic [Q_W-1:0]    qcnt;

  logic sclk_fall, sclk_rise, sclk_done;
  logic frame_end;

  ad1_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk       (clk),
    .reset_b   (reset_b),
    .clr       (state != SHIFT),
    .run       (state == SHIFT),
    .sclk      (adc_sclk),
    .fall_tick (sclk_fall),
    .rise_tick (sclk_rise),
    .done      (sclk_done)
  );

  assign frame_end = sclk_done && sclk_rise && (bit_cnt == 5'(FRAME_BITS));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= IDLE;
      adc_cs_out   <= 1'b1;
      busy         <= 1'b0;
      bit_cnt      <= '0;
      sreg0        <= '0;
      sreg1        <= '0;
      qcnt         <= '0;
      sample0      <= '0;
      sample1      <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (conv_en) begin
            state      <= SHIFT;
            adc_cs_out <= 1'b0;
            busy       <= 1'b1;
            bit_cnt    <= '0;
          end
        end
        SHIFT: begin
          // Capture on the edge that lowers sclk: miso still holds the
          // bit the ADC presented before this fall.
          if (sclk_fall) begin
            sreg0   <= {sreg0[SREG_W-2:0], adc_miso0};
            sreg1   <= {sreg1[SREG_W-2:0], adc_miso1};
            bit_cnt <= bit_cnt + 5'd1;
          end
          if (frame_end) begin
            state        <= QUIET;
            adc_cs_out   <= 1'b1;
            busy         <= 1'b0;
            sample0      <= sreg0[DATA_BITS-1:0];
            sample1      <= sreg1[DATA_BITS-1:0];
            sample_valid <= 1'b1;
            qcnt         <= '0;
          end
        end
        QUIET: begin
          if (qcnt == Q_W'(QUIET_CLKS - 1)) begin
            qcnt <= '0;
            if (conv_en) begin
              state      <= SHIFT;
              adc_cs_out <= 1'b0;
              busy       <= 1'b1;
              bit_cnt    <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            qcnt <= qcnt + Q_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          adc_cs_out <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef AD1_LEAD_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      frame_err <= 1'b0;
    end else if (state == SHIFT && frame_end) begin
      frame_err <= (|sreg0[FRAME_BITS-1 -: LEAD_ZEROS]) |
                   (|sreg1[FRAME_BITS-1 -: LEAD_ZEROS]);
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmod_ad1_rx.sv
// Bench for pmod_ad1_rx: an ADC model shifts out fixed 16-bit words,
// an expected entry is queued at every CS fall, and a monitor checks
// each sample_valid against the queue head plus frame timing.
module tb_pmod_ad1_rx;

  localparam int CLK_DIV    = 4;
  localparam int QUIET_CLKS = 8;
  localparam int FRAME_CLKS = 32 * CLK_DIV;
  localparam int PERIOD     = FRAME_CLKS + QUIET_CLKS;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        conv_en = 1'b0;
  logic        adc_miso0, adc_miso1;
  logic        adc_cs_out, adc_sclk;
  logic [11:0] sample0, sample1;
  logic        sample_valid, busy, frame_err;

  pmod_ad1_rx #(.CLK_DIV(CLK_DIV), .QUIET_CLKS(QUIET_CLKS)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .conv_en      (conv_en),
    .adc_miso0    (adc_miso0),
    .adc_miso1    (adc_miso1),
    .adc_cs_out   (adc_cs_out),
    .adc_sclk     (adc_sclk),
    .sample0      (sample0),
    .sample1      (sample1),
    .sample_valid (sample_valid),
    .busy         (busy),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ADC model: bit (15-count) of the word, count advancing on sclk falls.
  logic [15:0] w0 = 16'h09B2;
  logic [15:0] w1 = 16'h03E8;
  int          bcnt = 16;

  assign adc_miso0 = (bcnt < 16) ? w0[15-bcnt] : 1'b0;
  assign adc_miso1 = (bcnt < 16) ? w1[15-bcnt] : 1'b0;

  function automatic logic lead_err(input logic [15:0] a, input logic [15:0] b);
`ifdef AD1_LEAD_ZERO_CHECK_EN
    return (a[15:12] != 4'h0) || (b[15:12] != 4'h0);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct packed {
    logic [11:0] s0;
    logic [11:0] s1;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  initial forever begin
    @(negedge adc_cs_out);
    bcnt = 0;
    exp_q.push_back(exp_t'{s0: w0[11:0], s1: w1[11:0], err: lead_err(w0, w1)});
  end

  initial forever begin
    @(negedge adc_sclk);
    if (!adc_cs_out && bcnt < 16) bcnt++;
  end

  // Monitor
  int   ncyc = 0;
  int   fall_cyc = 0;
  int   prev_valid = 0;
  bit   have_prev = 0;
  bit   b2b = 0;
  logic prev_cs = 1'b1;

  initial forever begin
    exp_t e;
    @(negedge clk);
    ncyc++;
    if (!reset_b) have_prev = 0;
    if (prev_cs === 1'b1 && adc_cs_out === 1'b0) begin
      fall_cyc = ncyc;
      chk("busy_in_frame", busy, 1);
    end
    prev_cs = adc_cs_out;
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", sample_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sample0", sample0, e.s0);
        chk("sample1", sample1, e.s1);
        chk("frame_err", frame_err, e.err);
        chk("valid_latency", ncyc - fall_cyc, FRAME_CLKS);
        if (b2b && have_prev) chk("valid_period", ncyc - prev_valid, PERIOD);
      end
      have_prev  = 1;
      prev_valid = ncyc;
    end
  end

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sample_valid !== 1'b1 && n < 400);
    if (sample_valid !== 1'b1) chk("valid_timeout", sample_valid, 1);
  endtask

  task automatic wait_cs_fall();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (adc_cs_out !== 1'b0 && n < 400);
    if (adc_cs_out !== 1'b0) chk("cs_fall_timeout", adc_cs_out, 0);
  endtask

  initial begin
    int bad;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset_b = 1'b0;
    #25 reset_b = 1'b1;

    // Idle after reset with conv_en low.
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (adc_cs_out !== 1'b1 || adc_sclk !== 1'b1 || sample_valid !== 1'b0 || busy !== 1'b0)
        bad++;
    end
    chk("idle_violations", bad, 0);
    chk("reset_cs", adc_cs_out, 1);
    chk("reset_sclk", adc_sclk, 1);
    chk("reset_sample0", sample0, 0);
    chk("reset_sample1", sample1, 0);
    chk("reset_frame_err", frame_err, 0);

    // Back-to-back frames with changing words.
    b2b = 1;
    conv_en = 1'b1;
    wait_valid();  w1 = 16'h0000;
    wait_valid();  w1 = 16'h04D9;
    wait_valid();  w1 = 16'h09B2;
    wait_valid();  w0 = 16'hF9B2;
    wait_valid();  w0 = 16'h09B2;
    repeat (50) @(negedge clk);
    chk("frame_err_hold", frame_err, lead_err(16'hF9B2, 16'h09B2));
    wait_valid();

    // Drop conv_en 40 clks into a frame: it finishes, then stays idle.
    wait_cs_fall();
    repeat (40) @(negedge clk);
    conv_en = 1'b0;
    wait_valid();
    b2b = 0;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (adc_cs_out !== 1'b1 || adc_sclk !== 1'b1) bad++;
    end
    chk("idle_after_drop", bad, 0);

    // Reset mid-SHIFT: outputs return at once, partial frame discarded.
    conv_en = 1'b1;
    wait_cs_fall();
    repeat (50) @(negedge clk);
    #3 reset_b = 1'b0;
    #1;
    chk("async_rst_cs", adc_cs_out, 1);
    chk("async_rst_sclk", adc_sclk, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", sample_valid, 0);
    chk("async_rst_sample0", sample0, 0);
    exp_q.delete();
    conv_en = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (5) @(negedge clk);
    conv_en = 1'b1;
    wait_valid();
    conv_en = 1'b0;
    repeat (200) @(negedge clk);
    chk("final_idle_cs", adc_cs_out, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmod_ad1_rx.md
Name: pmod_ad1_rx

Overview:
Master-side serial receiver for the PMOD AD1 dual-channel 12-bit ADC. It sits directly upstream of the PID datapath. Each frame it generates chip-select and serial clock, shifts in 16 bits from both MISO lines in parallel, and presents two 12-bit samples with a one-cycle valid strobe. Channel 0 carries the setpoint; channel 1 carries the process value.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (sclk = clk/(2*CLK_DIV)); legal values 2..255
QUIET_CLKS, 8, clk cycles that CS is held high between back-to-back frames; minimum 1

Ports:
clk  in  1  system clock
reset_b  in  1  asynchronous active-low reset
conv_en  in  1  level; while high, frames run back-to-back
adc_miso0  in  1  serial data, channel 0 (setpoint)
adc_miso1  in  1  serial data, channel 1 (process value)
adc_cs_out  out  1  ADC chip select, active low
adc_sclk  out  1  ADC serial clock, idles high
sample0  out  12  last completed channel-0 sample
sample1  out  12  last completed channel-1 sample
sample_valid  out  1  one-cycle pulse when sample0/sample1 update
busy  out  1  high whenever adc_cs_out is low
frame_err  out  1  leading-zero violation flag (see Optional Feature)

Behaviour:
- Clock is clk. Reset is reset_b: asynchronous, active-low.
- All outputs are registered. Reset values: adc_cs_out=1, adc_sclk=1, sample0=0, sample1=0, sample_valid=0, busy=0, frame_err=0. Reset state is IDLE.
- States: IDLE, SHIFT, QUIET.
- IDLE:
  - CS high, sclk high.
  - When conv_en=1 is sampled: go to SHIFT, drive CS low on that edge, clear the divider and bit counter.
- SHIFT:
  - Divider counts 0..CLK_DIV-1. At terminal count, sclk toggles.
  - First falling edge occurs CLK_DIV clks after CS falls.
  - On each clk edge that drives sclk high→low, capture adc_miso0 and adc_miso1 (the value present before the fall) into 16-bit shift registers, MSB first, and increment bit_cnt.
  - The ADC changes data after each sclk falling edge, so bit 15 is valid between CS fall and the first fall.
  - After 16 falls, the next terminal count (the 32nd toggle, at CS-fall + 32*CLK_DIV clks) does all of the following on the same edge:
    - drives sclk high and CS high;
    - loads sample0 = sreg0[11:0] and sample1 = sreg1[11:0];
    - pulses sample_valid for 1 clk;
    - goes to QUIET.
- QUIET:
  - CS high for QUIET_CLKS clks.
  - Then, if conv_en=1, go to SHIFT (CS falls). Otherwise go to IDLE.
- Frame period with conv_en held high: 32*CLK_DIV + QUIET_CLKS clks (136 with defaults).
- Bits [15:12] are discarded from the sample.
- Deasserting conv_en mid-frame does not abort: the frame completes and valid still pulses.
- Asserting reset_b low mid-frame: immediate return to reset values, with no sample_valid for the partial frame.
- sample0/sample1 hold their values between valid pulses.
- busy = ~adc_cs_out.

Optional Feature:
Macro AD1_LEAD_ZERO_CHECK_EN.
- Defined: at frame end, frame_err is registered high if sreg0[15:12] or sreg1[15:12] is nonzero. It updates on the same edge as sample_valid and holds until the next frame end. Samples are still delivered.
- Undefined: frame_err is tied to 0 and no check logic is built.

Decomposition:
- Package ad1_pkg holds:
  - state enum {IDLE, SHIFT, QUIET};
  - constants FRAME_BITS=16, DATA_BITS=12, LEAD_ZEROS=4.
- One sub-module is natural: ad1_sclk_gen. It holds the divider counter and sclk toggle register, and emits fall_tick/rise_tick strobes plus a 32-toggle done flag. The FSM and shift registers stay in pmod_ad1_rx.

Test Plan:
- Reset held 25 ns then released with conv_en=0 → CS=1, sclk=1, samples=0, no valid for 1000 clks.
- Bench model drives bit (15-count) of its word, count advancing on each sclk fall while CS is low. ch0=16'h09B2, ch1=16'h03E8, conv_en=1 → first valid at CS-fall+128 clks, with sample0=12'h9B2 and sample1=12'h3E8. Subsequent valids every 136 clks.
- ch1 word changes 16'h0000 → 16'h04D9 → 16'h09B2 between frames → sample1 follows 12'h000, 12'h4D9, 12'h9B2 on successive valids; sample0 stays at 12'h9B2.
- conv_en dropped at clk 40 of a frame → that frame completes with valid, CS stays high afterwards, FSM ends in IDLE.
- reset_b pulsed low mid-SHIFT → CS and sclk go high asynchronously, no valid pulse, and the next frame after re-enable captures correctly.
- With AD1_LEAD_ZERO_CHECK_EN defined and ch0=16'hF9B2 → frame_err=1 with sample0=12'h9B2; next frame with 16'h09B2 → frame_err=0. Without the macro, frame_err stays 0 throughout.
